// File: rtl/nosignal_box_scheduler_if.sv
// nosignal_box_scheduler_if: raster inputs and box overlay outputs of the no-signal scheduler.
//   p_tick, x, y, enable : raster position/strobe and screen-saver request (into scheduler)
//   box_x, box_y         : box top-left corner
//   box_color, box_en    : RGB444 colour and visibility
//   frame_tick           : one-cycle pulse after each frame strobe
//   bounce_count         : saturating bounce counter
interface nosignal_box_scheduler_if;
   logic        p_tick;
   logic [9:0]  x;
   logic [9:0]  y;
   logic        enable;
   logic [9:0]  box_x;
   logic [9:0]  box_y;
   logic [11:0] box_color;
   logic        box_en;
   logic        frame_tick;
   logic [7:0]  bounce_count;
   modport master (output p_tick, x, y, enable,
                   input box_x, box_y, box_color, box_en, frame_tick, bounce_count);
   modport slave (input p_tick, x, y, enable,
                  output box_x, box_y, box_color, box_en, frame_tick, bounce_count);
endinterface

// File: rtl/nosignal_box_scheduler.sv
// nosignal_box_scheduler: frame-rate sequencer for the "no signal" box (blank, hold at centre, bounce).
//   clk_100MHz, reset : system clock, synchronous active-high reset
//   bus (slave)       : raster inputs in, box position/colour/enable, frame_tick, bounce_count out
module nosignal_box_scheduler #(
   parameter int H_DISPLAY   = 640,
   parameter int V_DISPLAY   = 480,
   parameter int BOX_W       = 128,
   parameter int BOX_H       = 32,
   parameter int STEP        = 1,
   parameter int HOLD_FRAMES = 60
) (
   input logic                      clk_100MHz,
   input logic                      reset,
   nosignal_box_scheduler_if.slave  bus
);
   localparam logic [1:0]  BLANK  = 2'd0;
   localparam logic [1:0]  HOLD   = 2'd1;
   localparam logic [1:0]  BOUNCE = 2'd2;
   localparam logic [9:0]  CX     = 10'((H_DISPLAY - BOX_W) / 2);
   localparam logic [9:0]  CY     = 10'((V_DISPLAY - BOX_H) / 2);
   localparam logic [9:0]  XMAX   = 10'(H_DISPLAY - BOX_W);
   localparam logic [9:0]  YMAX   = 10'(V_DISPLAY - BOX_H);
   localparam logic [10:0] STP    = 11'(STEP);
   localparam logic [7:0]  HLAST  = 8'(HOLD_FRAMES - 1);
   localparam logic [11:0] PAL [8] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
                                       12'h0FF, 12'hF0F, 12'hFFF, 12'hF80};
   logic [1:0]  r_state;
   logic [7:0]  r_hold;
   logic [9:0]  r_x;
   logic [9:0]  r_y;
   logic        r_dx;
   logic        r_dy;
   logic [2:0]  r_pal;
   logic [7:0]  r_bc;
   logic        r_ft;
   logic        w_fs;
   logic [10:0] w_nx;
   logic [10:0] w_ny;
   // One axis step; dir 0 = increasing. Result is {edge_hit, next_position}.
   // The 11-bit sum keeps the upper-edge test free of wrap-around.
   function automatic logic [10:0] step_axis(input logic [9:0] p, input logic d, input logic [9:0] m);
      logic [10:0] w_up;
      w_up = {1'b0, p} + STP;
      step_axis = (!d && w_up >= {1'b0, m}) ? {1'b1, m} :
                  (d && {1'b0, p} <= STP)   ? 11'h400 :
                  {1'b0, d ? p - STP[9:0] : w_up[9:0]};
   endfunction
   assign w_fs = bus.p_tick && bus.x == 10'd0 && bus.y == 10'(V_DISPLAY);
   assign w_nx = step_axis(r_x, r_dx, XMAX);
   assign w_ny = step_axis(r_y, r_dy, YMAX);
   // Dropping enable restores exactly the reset picture, so both share one branch.
   always_ff @(posedge clk_100MHz) begin
      if (reset || !bus.enable) begin
         r_state <= BLANK;
         r_hold  <= 8'd0;
         r_x     <= CX;
         r_y     <= CY;
         r_dx    <= 1'b0;
         r_dy    <= 1'b0;
         r_pal   <= 3'd0;
         r_bc    <= 8'd0;
      end else if (r_state == BLANK) begin
         r_state <= HOLD;
         r_hold  <= 8'd0;
      end else if (w_fs) begin
         if (r_state == HOLD) begin
            r_hold <= r_hold + 8'd1;
            if (r_hold == HLAST) begin
               r_state <= BOUNCE;
               r_bc    <= 8'd0;
            end
         end else begin
            r_x  <= w_nx[9:0];
            r_y  <= w_ny[9:0];
            r_dx <= r_dx ^ w_nx[10];
            r_dy <= r_dy ^ w_ny[10];
            // A corner hit counts as a single bounce.
            if (w_nx[10] || w_ny[10]) begin
               r_pal <= r_pal + 3'd1;
               r_bc  <= r_bc + {7'd0, r_bc != 8'hFF};
            end
         end
      end
      r_ft <= !reset && w_fs;
   end
   assign bus.box_x        = r_x;
   assign bus.box_y        = r_y;
   assign bus.box_color    = PAL[r_pal];
   assign bus.box_en       = r_state != BLANK;
   assign bus.frame_tick   = r_ft;
   assign bus.bounce_count = r_bc;
endmodule
